// File: rtl/fir_led_sample_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Module      : fir_led_sample_scheduler_if
//  Description : Signal bundle between the LED/ADC sample scheduler and its
//                surroundings: run request, ADC conversion handshake, LED
//                drives, RED/IR filter push channels, filter-status flags.
//                master = scheduler side, slave = environment side.
//  Signals     : enable, adc_data[7:0], adc_done       (environment -> sched)
//                adc_start, led_red, led_ir,
//                red_push, red_sample[7:0], ir_push, ir_sample[7:0],
//                red_ready, ir_ready, red_out_valid, ir_out_valid,
//                adc_timeout_err                       (sched -> environment)
//  Revision    : 1.0  initial release
// ============================================================================
interface fir_led_sample_scheduler_if;
  logic       enable;
  logic [7:0] adc_data;
  logic       adc_done;
  logic       adc_start;
  logic       led_red;
  logic       led_ir;
  logic       red_push;
  logic [7:0] red_sample;
  logic       ir_push;
  logic [7:0] ir_sample;
  logic       red_ready;
  logic       ir_ready;
  logic       red_out_valid;
  logic       ir_out_valid;
  logic       adc_timeout_err;

  modport master (
    input  enable, adc_data, adc_done,
    output adc_start, led_red, led_ir,
    output red_push, red_sample, ir_push, ir_sample,
    output red_ready, ir_ready, red_out_valid, ir_out_valid,
    output adc_timeout_err
  );

  modport slave (
    output enable, adc_data, adc_done,
    input  adc_start, led_red, led_ir,
    input  red_push, red_sample, ir_push, ir_sample,
    input  red_ready, ir_ready, red_out_valid, ir_out_valid,
    input  adc_timeout_err
  );
endinterface
`default_nettype wire

// File: rtl/fir_led_sample_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : fir_led_sample_scheduler
//  Description : Pulse-oximeter front-end sequencer. Alternates red / IR LED
//                phases of PHASE_CYC cycles, waits SETTLE_CYC cycles, runs one
//                ADC handshake per phase and pushes the captured byte to the
//                RED or IR FIR channel. Tracks per-channel tap fill (ready)
//                and flags filtered outputs PIPE_LAT cycles after warm pushes.
//  Ports       : CLK_Filter  - filter clock
//                rst_n       - asynchronous active-low reset
//                bus         - fir_led_sample_scheduler_if.master (see interface)
//  Revision    : 1.0  initial release
// ============================================================================
module fir_led_sample_scheduler #(
  parameter int PHASE_CYC   = 500,
  parameter int SETTLE_CYC  = 100,
  parameter int ADC_TIMEOUT = 200,
  parameter int TAPS        = 22,
  parameter int PIPE_LAT    = 3
) (
  input  logic                               CLK_Filter,
  input  logic                               rst_n,
  fir_led_sample_scheduler_if.master         bus
);

  localparam int PW = (PHASE_CYC > 1) ? $clog2(PHASE_CYC) : 1;
  localparam int WW = (ADC_TIMEOUT > 1) ? $clog2(ADC_TIMEOUT) : 1;
  localparam int CW = $clog2(TAPS + 1);

  localparam logic [PW-1:0] c_phase_last   = PW'(PHASE_CYC - 1);
  localparam logic [PW-1:0] c_settle_last  = PW'(SETTLE_CYC - 1);
  localparam logic [WW-1:0] c_timeout_last = WW'(ADC_TIMEOUT - 1);
  localparam logic [CW-1:0] c_taps_full    = CW'(TAPS);
  localparam logic [CW-1:0] c_taps_warm    = CW'(TAPS - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_SETTLE    = 3'd1,
    S_CONVERT   = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_PUSH      = 3'd4,
    S_HOLD      = 3'd5
  } state_t;

  state_t        r_state;
  logic [PW-1:0] r_phase_cnt;
  logic          r_colour_ir;   // 0 = RED phase, 1 = IR phase
  logic [WW-1:0] r_wait_cnt;
  logic          r_adc_start;
  logic          r_led_red;
  logic          r_led_ir;
  logic          r_red_push;
  logic          r_ir_push;
  logic [7:0]    r_red_sample;
  logic [7:0]    r_ir_sample;
  logic [CW-1:0] r_red_cnt;
  logic [CW-1:0] r_ir_cnt;
  logic          r_red_ready;
  logic          r_ir_ready;
  logic          r_timeout_err;

  logic [PIPE_LAT-1:0] r_red_vpipe;
  logic [PIPE_LAT-1:0] r_ir_vpipe;

  logic w_red_warm;
  logic w_ir_warm;

  // --------------------------------------------------------------------------
  // Sequencer. The phase counter and colour run independently of the state;
  // a phase wrap pulls any non-idle state back to SETTLE, abandoning an
  // in-flight conversion. All strobes are registered and default low.
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK_Filter or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_phase_cnt   <= '0;
      r_colour_ir   <= 1'b0;
      r_wait_cnt    <= '0;
      r_adc_start   <= 1'b0;
      r_led_red     <= 1'b0;
      r_led_ir      <= 1'b0;
      r_red_push    <= 1'b0;
      r_ir_push     <= 1'b0;
      r_red_sample  <= '0;
      r_ir_sample   <= '0;
      r_red_cnt     <= '0;
      r_ir_cnt      <= '0;
      r_red_ready   <= 1'b0;
      r_ir_ready    <= 1'b0;
      r_timeout_err <= 1'b0;
    end else if (!bus.enable) begin
      // Stop: everything except the sample registers returns to idle values.
      r_state       <= S_IDLE;
      r_phase_cnt   <= '0;
      r_colour_ir   <= 1'b0;
      r_wait_cnt    <= '0;
      r_adc_start   <= 1'b0;
      r_led_red     <= 1'b0;
      r_led_ir      <= 1'b0;
      r_red_push    <= 1'b0;
      r_ir_push     <= 1'b0;
      r_red_cnt     <= '0;
      r_ir_cnt      <= '0;
      r_red_ready   <= 1'b0;
      r_ir_ready    <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_adc_start <= 1'b0;
      r_red_push  <= 1'b0;
      r_ir_push   <= 1'b0;

      if (r_state == S_IDLE) begin
        // Every run opens with a RED phase at count 0.
        r_state     <= S_SETTLE;
        r_phase_cnt <= '0;
        r_colour_ir <= 1'b0;
        r_led_red   <= 1'b1;
        r_led_ir    <= 1'b0;
      end else if (r_phase_cnt == c_phase_last) begin
        r_state     <= S_SETTLE;
        r_phase_cnt <= '0;
        r_colour_ir <= ~r_colour_ir;
        r_led_red   <= r_colour_ir;
        r_led_ir    <= ~r_colour_ir;
      end else begin
        r_phase_cnt <= r_phase_cnt + 1'b1;
        case (r_state)
          S_SETTLE: begin
            if (r_phase_cnt == c_settle_last) begin
              r_state     <= S_CONVERT;
              r_adc_start <= 1'b1;
            end
          end
          S_CONVERT: begin
            r_state    <= S_WAIT_DONE;
            r_wait_cnt <= '0;
          end
          S_WAIT_DONE: begin
            if (bus.adc_done) begin
              r_state <= S_PUSH;
              // Counter and ready update on the same edge that raises the
              // push, so ready rises together with the TAPS-th push.
              if (r_colour_ir) begin
                r_ir_sample <= bus.adc_data;
                r_ir_push   <= 1'b1;
                r_ir_ready  <= (r_ir_cnt >= c_taps_warm);
                if (r_ir_cnt != c_taps_full) begin
                  r_ir_cnt <= r_ir_cnt + 1'b1;
                end
              end else begin
                r_red_sample <= bus.adc_data;
                r_red_push   <= 1'b1;
                r_red_ready  <= (r_red_cnt >= c_taps_warm);
                if (r_red_cnt != c_taps_full) begin
                  r_red_cnt <= r_red_cnt + 1'b1;
                end
              end
            end else if (r_wait_cnt == c_timeout_last) begin
              r_state       <= S_HOLD;
              r_timeout_err <= 1'b1;
            end else begin
              r_wait_cnt <= r_wait_cnt + 1'b1;
            end
          end
          S_PUSH: begin
            r_state <= S_HOLD;
          end
          S_HOLD: begin
            r_state <= S_HOLD;
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  // --------------------------------------------------------------------------
  // Output-valid tracking. During a push cycle the channel count already
  // includes that push, so "count was TAPS-1 or TAPS when issued" reads as
  // count >= TAPS-1 here. Each warm push walks a PIPE_LAT-deep shift register.
  // --------------------------------------------------------------------------
  assign w_red_warm = r_red_push && (r_red_cnt >= c_taps_warm);
  assign w_ir_warm  = r_ir_push  && (r_ir_cnt  >= c_taps_warm);

  always_ff @(posedge CLK_Filter or negedge rst_n) begin
    if (!rst_n) begin
      r_red_vpipe <= '0;
      r_ir_vpipe  <= '0;
    end else if (!bus.enable) begin
      r_red_vpipe <= '0;
      r_ir_vpipe  <= '0;
    end else begin
      r_red_vpipe <= (r_red_vpipe << 1) | PIPE_LAT'(w_red_warm);
      r_ir_vpipe  <= (r_ir_vpipe  << 1) | PIPE_LAT'(w_ir_warm);
    end
  end

  assign bus.adc_start       = r_adc_start;
  assign bus.led_red         = r_led_red;
  assign bus.led_ir          = r_led_ir;
  assign bus.red_push        = r_red_push;
  assign bus.red_sample      = r_red_sample;
  assign bus.ir_push         = r_ir_push;
  assign bus.ir_sample       = r_ir_sample;
  assign bus.red_ready       = r_red_ready;
  assign bus.ir_ready        = r_ir_ready;
  assign bus.red_out_valid   = r_red_vpipe[PIPE_LAT-1];
  assign bus.ir_out_valid    = r_ir_vpipe[PIPE_LAT-1];
  assign bus.adc_timeout_err = r_timeout_err;

endmodule
`default_nettype wire

// File: tb/tb_fir_led_sample_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fir_led_sample_scheduler
//  Description : Self-checking bench for fir_led_sample_scheduler. Expected
//                pushes go into a scoreboard queue when the bench answers an
//                adc_start; LEDs, adc_start, ready, out_valid and the timeout
//                flag come from a time-based model of the run.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fir_led_sample_scheduler;
  localparam int PHASE  = 500;
  localparam int SETTLE = 100;
  localparam int TMO    = 200;
  localparam int TAPS   = 22;
  localparam int LAT    = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fir_led_sample_scheduler_if bus();

  fir_led_sample_scheduler #(
    .PHASE_CYC(PHASE), .SETTLE_CYC(SETTLE), .ADC_TIMEOUT(TMO),
    .TAPS(TAPS), .PIPE_LAT(LAT)
  ) dut (
    .CLK_Filter(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  typedef struct {
    int         due;
    bit         ir;
    logic [7:0] data;
  } push_t;

  typedef struct {
    int t;
    bit lr;
    bit li;
    bit st;
    bit rp;
    bit ip;
  } vec_t;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int run_t    = -1;   // cycles since run start; -1 when idle
  push_t sbq[$];
  int red_vq[$];
  int ir_vq[$];
  int red_cnt = 0;
  int ir_cnt  = 0;
  logic [7:0] exp_red_s = 8'h00;
  logic [7:0] exp_ir_s  = 8'h00;
  bit exp_err = 1'b0;
  int err_due = -1;
  bit pend    = 1'b0;
  int withhold_phase = -1;
  int stray_phase    = -1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d run_t=%0d got=%0h expected=%0h", name, cyc, run_t, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".adc_start"},  bus.adc_start, 0);
    check({tag, ".led_red"},    bus.led_red, 0);
    check({tag, ".led_ir"},     bus.led_ir, 0);
    check({tag, ".red_push"},   bus.red_push, 0);
    check({tag, ".ir_push"},    bus.ir_push, 0);
    check({tag, ".red_ready"},  bus.red_ready, 0);
    check({tag, ".ir_ready"},   bus.ir_ready, 0);
    check({tag, ".red_valid"},  bus.red_out_valid, 0);
    check({tag, ".ir_valid"},   bus.ir_out_valid, 0);
    check({tag, ".timeout"},    bus.adc_timeout_err, 0);
  endtask

  // One clock: advance the model, compare every output, then drive inputs
  // for the new cycle (ADC responder and stray adc_done injection).
  task automatic step();
    bit was_en;
    bit exp_rp, exp_ip, exp_rv, exp_iv, running;
    int ph, off;
    was_en = bus.enable;
    @(posedge clk);
    #1;
    cyc++;
    if (was_en) begin
      run_t = (run_t < 0) ? 0 : run_t + 1;
    end else begin
      run_t = -1; red_cnt = 0; ir_cnt = 0;
      red_vq.delete(); ir_vq.delete(); sbq.delete();
      exp_err = 1'b0; err_due = -1; pend = 1'b0;
    end
    if (err_due == cyc) exp_err = 1'b1;

    exp_rp = 1'b0; exp_ip = 1'b0;
    if (sbq.size() > 0 && sbq[0].due == cyc) begin
      push_t e;
      e = sbq.pop_front();
      if (e.ir) begin
        exp_ip = 1'b1; exp_ir_s = e.data;
        if (ir_cnt < TAPS) ir_cnt++;
        if (ir_cnt >= TAPS - 1) ir_vq.push_back(cyc + LAT);
      end else begin
        exp_rp = 1'b1; exp_red_s = e.data;
        if (red_cnt < TAPS) red_cnt++;
        if (red_cnt >= TAPS - 1) red_vq.push_back(cyc + LAT);
      end
    end
    exp_rv = (red_vq.size() > 0 && red_vq[0] == cyc);
    if (exp_rv) void'(red_vq.pop_front());
    exp_iv = (ir_vq.size() > 0 && ir_vq[0] == cyc);
    if (exp_iv) void'(ir_vq.pop_front());

    running = (run_t >= 0);
    ph  = running ? run_t / PHASE : 0;
    off = running ? run_t % PHASE : 0;

    check("red_push",   bus.red_push, exp_rp);
    check("ir_push",    bus.ir_push, exp_ip);
    check("red_sample", bus.red_sample, exp_red_s);
    check("ir_sample",  bus.ir_sample, exp_ir_s);
    check("red_ready",  bus.red_ready, red_cnt == TAPS);
    check("ir_ready",   bus.ir_ready, ir_cnt == TAPS);
    check("red_out_valid", bus.red_out_valid, exp_rv);
    check("ir_out_valid",  bus.ir_out_valid, exp_iv);
    check("led_red",    bus.led_red, running && (ph % 2 == 0));
    check("led_ir",     bus.led_ir, running && (ph % 2 == 1));
    check("leds_exclusive", bus.led_red & bus.led_ir, 0);
    check("adc_start",  bus.adc_start, running && (off == SETTLE));
    check("adc_timeout_err", bus.adc_timeout_err, exp_err);

    bus.adc_done = 1'b0;
    bus.adc_data = 8'h00;
    if (pend && running) begin
      pend = 1'b0;
      bus.adc_done = 1'b1;
      bus.adc_data = (ph % 2 == 1) ? 8'h3C : 8'hA5;
      sbq.push_back('{cyc + 1, (ph % 2 == 1), bus.adc_data});
    end else if (running && ph == stray_phase && (off == 50 || off == 300)) begin
      bus.adc_done = 1'b1;
      bus.adc_data = 8'hFF;
    end
    if (running && bus.adc_start) begin
      if (ph == withhold_phase) err_due = cyc + 1 + TMO;
      else pend = 1'b1;
    end
  endtask

  task automatic run_until(input int target);
    int guard;
    guard = 0;
    while (run_t != target && guard < 30000) begin
      step();
      guard++;
    end
    if (run_t != target) begin
      failures++;
      $display("FAIL run_until timeout target=%0d got run_t=%0d", target, run_t);
    end
  endtask

  vec_t vecs[12];

  initial begin
    // run_t-relative expectations for the first period
    vecs[0]  = '{0,    1, 0, 0, 0, 0};
    vecs[1]  = '{99,   1, 0, 0, 0, 0};
    vecs[2]  = '{100,  1, 0, 1, 0, 0};
    vecs[3]  = '{101,  1, 0, 0, 0, 0};
    vecs[4]  = '{102,  1, 0, 0, 1, 0};
    vecs[5]  = '{103,  1, 0, 0, 0, 0};
    vecs[6]  = '{499,  1, 0, 0, 0, 0};
    vecs[7]  = '{500,  0, 1, 0, 0, 0};
    vecs[8]  = '{600,  0, 1, 1, 0, 0};
    vecs[9]  = '{602,  0, 1, 0, 0, 1};
    vecs[10] = '{1000, 1, 0, 0, 0, 0};
    vecs[11] = '{1100, 1, 0, 1, 0, 0};

    rst_n = 1'b0;
    bus.enable = 1'b0;
    bus.adc_done = 1'b0;
    bus.adc_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    check("reset.red_sample", bus.red_sample, 0);
    check("reset.ir_sample",  bus.ir_sample, 0);
    rst_n = 1'b1;
    step();
    step();

    // Normal run: responder answers one cycle after each adc_start.
    bus.enable = 1'b1;
    for (int i = 0; i < 12; i++) begin
      run_until(vecs[i].t);
      check("vec.led_red",   bus.led_red, vecs[i].lr);
      check("vec.led_ir",    bus.led_ir, vecs[i].li);
      check("vec.adc_start", bus.adc_start, vecs[i].st);
      check("vec.red_push",  bus.red_push, vecs[i].rp);
      check("vec.ir_push",   bus.ir_push, vecs[i].ip);
      if (vecs[i].rp) check("vec.red_sample", bus.red_sample, 8'hA5);
      if (vecs[i].ip) check("vec.ir_sample",  bus.ir_sample, 8'h3C);
    end

    // Fill: red push 21 at 20102 -> first valid at 20105; ready at push 22.
    run_until(20104);
    check("first_valid_early", bus.red_out_valid, 0);
    step();
    check("first_valid", bus.red_out_valid, 1);
    run_until(21101);
    check("red_ready_before", bus.red_ready, 0);
    step();
    check("red_ready_rise", bus.red_ready, 1);
    run_until(21105);
    check("valid_repeat_1000", bus.red_out_valid, 1);
    run_until(21602);
    check("ir_ready_rise", bus.ir_ready, 1);
    run_until(22150);

    // Stray adc_done in SETTLE and HOLD of IR phase 45; timeout in IR phase 47.
    stray_phase    = 45;
    withhold_phase = 47;
    run_until(45 * PHASE + 301);
    check("stray.red_sample", bus.red_sample, 8'hA5);
    check("stray.ir_sample",  bus.ir_sample, 8'h3C);
    run_until(47 * PHASE + SETTLE + TMO);
    check("timeout_early", bus.adc_timeout_err, 0);
    step();
    check("timeout_rise", bus.adc_timeout_err, 1);
    run_until(48 * PHASE + 102);
    check("after_timeout.red_push", bus.red_push, 1);
    check("timeout_sticky", bus.adc_timeout_err, 1);

    // Drop enable one cycle after a warm push.
    step();
    bus.enable = 1'b0;
    step();
    check_all_zero("disable");
    check("disable.red_sample", bus.red_sample, 8'hA5);
    repeat (4) step();
    check("flushed_valid", bus.red_out_valid, 0);

    // Re-enable: RED phase first again.
    bus.enable = 1'b1;
    withhold_phase = -1;
    stray_phase    = -1;
    step();
    check("restart.led_red", bus.led_red, 1);
    check("restart.led_ir",  bus.led_ir, 0);
    run_until(102);
    check("restart.red_push",  bus.red_push, 1);
    check("restart.red_ready", bus.red_ready, 0);

    // Asynchronous reset while waiting in WAIT_DONE.
    withhold_phase = 1;
    run_until(PHASE + SETTLE + 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    check("async_reset.red_sample", bus.red_sample, 0);
    check("async_reset.ir_sample",  bus.ir_sample, 0);
    bus.enable = 1'b0;
    bus.adc_done = 1'b0;
    repeat (2) @(posedge clk);
    run_t = -1; red_cnt = 0; ir_cnt = 0;
    red_vq.delete(); ir_vq.delete(); sbq.delete();
    exp_red_s = 8'h00; exp_ir_s = 8'h00;
    exp_err = 1'b0; err_due = -1; pend = 1'b0;
    withhold_phase = -1;
    #1;
    rst_n = 1'b1;
    repeat (3) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fir_led_sample_scheduler.md
# fir_led_sample_scheduler

Sequencing controller for the pulse-oximeter front end. It alternates the finger-clip LEDs between red and infrared at a fixed phase length. In each phase it waits for the LED to settle, then runs one ADC conversion handshake. It routes the captured 8-bit sample to the RED or IR FIR channel as a one-cycle push strobe. It also tracks each channel's tap fill and pipeline latency, so it can flag when the filtered outputs are valid.

## Interface
Parameters:
- PHASE_CYC, 500: CLK_Filter cycles per LED colour phase; a red+IR pair is one 2*PHASE_CYC period.
- SETTLE_CYC, 100: cycles from phase start to the ADC start pulse.
- ADC_TIMEOUT, 200: maximum cycles to wait for adc_done.
- TAPS, 22: number of samples needed to fill a filter delay line.
- PIPE_LAT, 3: cycles from a push to the matching filtered output.
- Legal range: SETTLE_CYC ≥ 1, PIPE_LAT ≥ 1, and SETTLE_CYC + ADC_TIMEOUT + 3 ≤ PHASE_CYC.

Ports:
- CLK_Filter  in  1  system clock.
- rst_n  in  1  reset: asynchronous, active-low.
- enable  in  1  run request; low forces IDLE.
- adc_data  in  8  conversion result; valid only in the adc_done cycle.
- adc_done  in  1  one-cycle conversion-complete strobe.
- adc_start  out  1  one-cycle conversion request.
- led_red  out  1  red LED drive.
- led_ir  out  1  IR LED drive.
- red_push  out  1  one-cycle strobe: red_sample is valid.
- red_sample  out  8  sample for the RED filter; holds its value between pushes.
- ir_push  out  1  one-cycle strobe: ir_sample is valid.
- ir_sample  out  8  sample for the IR filter; holds its value between pushes.
- red_ready  out  1  high once TAPS red pushes have occurred since run start.
- ir_ready  out  1  high once TAPS IR pushes have occurred since run start.
- red_out_valid  out  1  pulse marking a valid RED filter output.
- ir_out_valid  out  1  pulse marking a valid IR filter output.
- adc_timeout_err  out  1  sticky flag: an ADC conversion timed out.

## Operation
- FSM states: IDLE, SETTLE, CONVERT, WAIT_DONE, PUSH, HOLD.
- IDLE → SETTLE when enable is high. The first phase is always RED; phase_cnt starts at 0.
- phase_cnt counts 0..PHASE_CYC-1 independently of the FSM state.
  - At wrap, the colour toggles and the FSM enters SETTLE.
  - The FSM wraps from any non-IDLE state, abandoning any conversion in progress.
- LEDs:
  - led_red = running and colour is RED; led_ir = running and colour is IR.
  - The two LEDs are never high together. Both are low in IDLE.
- SETTLE → CONVERT when phase_cnt == SETTLE_CYC-1.
- CONVERT asserts adc_start for exactly one cycle, then goes to WAIT_DONE.
- WAIT_DONE on adc_done:
  - latch adc_data into the current colour's sample register, then go to PUSH.
- WAIT_DONE with ADC_TIMEOUT cycles elapsed and no adc_done:
  - set adc_timeout_err, go to HOLD, no push this phase.
- PUSH pulses red_push or ir_push, according to colour, for one cycle, then goes to HOLD.
- HOLD waits for phase wrap.
- adc_done outside WAIT_DONE is ignored, and the sample registers do not change.
- Per-channel push counter: saturates at TAPS; the ready output = (count == TAPS).
- Output-valid tracking:
  - A push issued while the channel's count is TAPS-1 or TAPS is "warm".
  - Each warm push produces a *_out_valid pulse exactly PIPE_LAT cycles later. Track this with a PIPE_LAT-deep shift register per channel.
- enable low (checked every cycle): next cycle the block is in IDLE, with:
  - phase_cnt = 0 and colour = RED;
  - LEDs off and no strobes;
  - push counters cleared and valid pipelines flushed;
  - adc_timeout_err cleared.
- Reset mid-run behaves like enable low, and additionally zeroes the sample registers.

## Timing
- Reset values: every output is 0, including red_sample and ir_sample.
- Taking the enable rise cycle as t=0:
  - phase_cnt = 0 and led_red = 1 at t+1;
  - adc_start at t+1+SETTLE_CYC.
- adc_done arriving in cycle d: *_push and the new *_sample are visible at d+1.
- Minimum push latency from adc_start is 2 cycles (adc_done in the cycle after adc_start).
- Timeout: adc_timeout_err rises ADC_TIMEOUT cycles after entry to WAIT_DONE.
- *_ready rises in the same cycle as the TAPS-th push.
- Throughput: at most one push per phase, i.e. one sample per channel per 2*PHASE_CYC cycles.

## Test plan
- Reset, then enable=1 with adc_done one cycle after each adc_start:
  - led_red for 500 cycles, then led_ir for 500;
  - adc_start at phase offset 100;
  - red_push at offset 102 with red_sample = adc_data;
  - the LEDs are never both high.
- adc_data = 8'hA5 in red phases and 8'h3C in IR phases for 22 periods:
  - red_ready and ir_ready rise on the 22nd push of each channel;
  - the first red_out_valid occurs 3 cycles after red push 21;
  - red_out_valid then repeats every 1000 cycles.
- adc_done withheld in one IR phase:
  - adc_timeout_err rises at WAIT_DONE entry + 200 and stays high;
  - no ir_push occurs, and the next red phase proceeds normally.
- adc_done pulsed during SETTLE and HOLD:
  - no push occurs and the sample registers are unchanged.
- enable dropped one cycle after a push:
  - next cycle all outputs are 0 (samples hold), the counters clear and the pending out_valid is flushed;
  - re-enable restarts with the RED phase.
- rst_n asserted in WAIT_DONE: all outputs are 0 asynchronously.
